mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer that shares the core's single byte-laned memory port between instruction fetch and data load/store. It sits between the MIPS core's fetch and data request interfaces and the memory model, which answers a fixed number of cycles after an address is presented. It serialises the two requesters, holds the address and write data stable for the whole access, returns read data with a one-cycle acknowledge, and drives the core stall.

## Interface
- MEM_LATENCY, 2, cycles the memory needs from a stable address to valid `mem_rdata`; legal range 1..15.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits. Used only with the guard compiled in.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- halted  in  1  core halted; no new grants while high.
- if_req  in  1  fetch request; held until `if_ack`.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while `if_ack`.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held until `d_ack`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store word.
- d_rdata  out  32  load word; valid while `d_ack`.
- d_ack  out  1  one-cycle data completion pulse.
- mem_addr  out  32  word-aligned memory address.
- mem_we  out  1  memory write enable.
- mem_data_in  out  8 x [0:3]  store bytes; lane 0 = bits [31:24].
- mem_data_out  in  8 x [0:3]  read bytes; lane 0 = bits [31:24].
- stall  out  1  core stall: (if_req & ~if_ack) | (d_req & ~d_ack).

## Operation
- FSM states and transitions:
  - IDLE: if `halted` is 0 and any request is pending, grant one requester and go to BUSY.
  - BUSY: stay for MEM_LATENCY cycles, counted by a down-counter of width clog2(MEM_LATENCY+1), then go to RESP.
  - RESP: one cycle; go to IDLE.
- Arbitration priority: data over fetch, because the data access belongs to the older instruction.
- On a grant, register the following:
  - the requester id;
  - the address, forced to {addr[31:2], 2'b00};
  - `d_we`;
  - `d_wdata`.
- Address outputs:
  - `mem_addr` is driven from the registered address throughout BUSY.
  - `mem_addr` is 0 in IDLE and RESP.
- Store behaviour:
  - `mem_we` is 1 only in the first BUSY cycle of a store.
  - `mem_data_in` is held for the whole of BUSY.
  - `mem_data_in` is 0 when the arbiter is not in BUSY.
- Read data:
  - On the edge leaving BUSY, capture {lane0, lane1, lane2, lane3} into the read register.
  - During RESP, the granted requester's ack = 1 and its rdata = the captured word.
  - For a store, d_rdata = 0.
- Requester contract:
  - Keep req, addr, we and wdata stable until ack.
  - On the edge that ends the ack cycle, either drop req or present a new request.
- Arbiter-side rules:
  - Requests that change while in BUSY are ignored.
  - An ack never goes to the non-granted requester.
- Halt:
  - `halted` rising during BUSY lets the access finish normally.
  - While `halted` is high, IDLE grants nothing.
- Reset, whenever asserted:
  - state = IDLE, and the in-flight access is dropped;
  - mem_we = 0, mem_addr = 0, mem_data_in = 0;
  - if_ack = d_ack = 0, if_rdata = d_rdata = 0;
  - starvation counter = 0.

## Timing
- Request-to-ack latency: a grant at edge T gives ack high in cycle T+MEM_LATENCY+1.
- Back-to-back throughput: the next grant is no earlier than the edge ending the IDLE cycle after RESP, i.e. MEM_LATENCY+2 cycles per access.
- If both requests arrive in the same IDLE cycle, data is granted and fetch waits one full access.
- `stall` is combinational from req/ack and is never registered.
- `mem_we` is a single cycle per store, even when MEM_LATENCY = 1.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter (0..STARVE_LIMIT) increments on each data grant made while `if_req` = 1.
  - When the counter equals STARVE_LIMIT and both requests are pending, fetch wins.
  - The counter clears on any fetch grant, and on any data grant made while `if_req` = 0.
- Undefined:
  - Strict data priority; the counter logic is absent.
  - STARVE_LIMIT is ignored.

## Test plan
- Single fetch, MEM_LATENCY=2, if_addr=0x0000_0006, memory word 0xDEADBEEF at 0x4 → mem_addr=0x4 for 2 cycles, if_ack pulse 3 cycles after the grant edge, if_rdata=0xDEADBEEF.
- Store d_addr=0x10, d_wdata=0x11223344 → mem_we high exactly one cycle, lanes 0..3 = 0x11,0x22,0x33,0x44; a following load from 0x10 returns 0x11223344.
- Simultaneous if_req and d_req from IDLE → d_ack first and stall held meanwhile; if_ack follows MEM_LATENCY+2 cycles later.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, d_req held continuously with if_req pending → exactly 4 d_acks, then 1 if_ack, then data resumes. Without the macro → no if_ack until d_req drops.
- rst pulsed mid-BUSY of a store → mem_we and the acks go 0 immediately, no ack is issued, and the first grant after reset release proceeds normally.
- halted=1 with both requests pending in IDLE → no grant and mem_addr=0 for 10 cycles; drop halted → data is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one byte-laned memory port between instruction fetch and data access, data first.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halted,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_data_in  [0:3],
   input  logic [7:0]  mem_data_out [0:3],
   output logic        stall
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             grant;
   logic             pick_d;
   logic             gnt_d;
   logic             first;
   logic             we_p0;
   logic [31:0]      addr_p0;
   logic [31:0]      wdata_p0;
   logic [31:0]      rdata_p1;
   logic             busy;
   logic             resp;
   logic             last_busy;
   logic             unused_bits;

   assign unused_bits = ^{if_addr[1:0], d_addr[1:0], 1'(STARVE_LIMIT)};

`ifdef ARB_STARVE_GUARD_EN
   localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_cnt;
   logic            starved;

   assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));
   // Once data has won STARVE_LIMIT times in a row over a waiting fetch, fetch goes next.
   assign pick_d  = d_req & ~(if_req & starved);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (pick_d && if_req) starve_cnt <= starve_cnt + SC_W'(1);
         else                  starve_cnt <= '0;
      end
   end
`else
   assign pick_d = d_req;
`endif

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (!halted && (if_req || d_req)) begin
               grant     = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         gnt_d <= 1'b0;
         we_p0 <= 1'b0;
         first <= 1'b0;
      end else begin
         state <= state_nxt;
         first <= grant;
         if (grant) begin
            cnt   <= CNT_W'(MEM_LATENCY);
            gnt_d <= pick_d;
            we_p0 <= pick_d & d_we;
         end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign busy      = (state == BUSY);
   assign resp      = (state == RESP);
   assign last_busy = busy && (cnt == CNT_W'(1));

   // Grant stage: address and store word latched for the whole access.
   always_ff @(posedge clk) begin
      if (grant) begin
         addr_p0  <= pick_d ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
         wdata_p0 <= d_wdata;
      end
   end

   // Response stage: read word captured on the edge leaving BUSY.
   always_ff @(posedge clk) begin
      if (last_busy) begin
         rdata_p1 <= {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
      end
   end

   assign mem_addr = busy ? addr_p0 : 32'h0;
   assign mem_we   = busy & first & we_p0;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         mem_data_in[k] = busy ? wdata_p0[31-8*k -: 8] : 8'h00;
      end
   end

   assign if_ack   = resp & ~gnt_d;
   assign d_ack    = resp & gnt_d;
   assign if_rdata = if_ack ? rdata_p1 : 32'h0;
   assign d_rdata  = (d_ack && !we_p0) ? rdata_p1 : 32'h0;
   assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
